// File: rtl/ex_mem_pipe_fwd_if.sv
// EX->MEM pipeline bus: EX bundle, MEM entry, MEM/WB writeback snoop and EX forwarding controls.
interface ex_mem_pipe_fwd_if #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned RADDR_W = 5
);
   logic                flush;
   logic                ex_valid;
   logic                ex_ready;
   logic [RADDR_W-1:0]  ex_rs1_addr;
   logic [RADDR_W-1:0]  ex_rs2_addr;
   logic [RADDR_W-1:0]  ex_reg_wr_addr;
   logic                ex_RegWrite;
   logic                ex_MemRead;
   logic                ex_MemWrite;
   logic [2:0]          ex_mem_mask;
   logic [XLEN-1:0]     ex_reg_wr_data;
   logic [XLEN-1:0]     ex_mem_wr_data;
   logic [XLEN-1:0]     ex_pc;
   logic [31:0]         ex_inst;

   logic                mem_valid;
   logic                mem_ready;
   logic [RADDR_W-1:0]  mem_reg_wr_addr;
   logic                mem_RegWrite;
   logic                mem_MemRead;
   logic                mem_MemWrite;
   logic [2:0]          mem_mem_mask;
   logic [XLEN-1:0]     mem_reg_wr_data;
   logic [XLEN-1:0]     mem_mem_wr_data;
   logic [XLEN-1:0]     mem_pc;
   logic [31:0]         mem_inst;

   logic                wb_RegWrite;
   logic [RADDR_W-1:0]  wb_reg_wr_addr;
   logic [XLEN-1:0]     wb_reg_wr_data;

   logic [1:0]          fw_src1fw;
   logic [1:0]          fw_src2fw;
   logic [XLEN-1:0]     fw_ex_mem_data;
   logic [XLEN-1:0]     fw_mem_wb_data;
   logic                load_use_stall;

   // Pipeline/control side that drives EX bundles and consumes MEM entries
   modport master (
      output flush, ex_valid, ex_rs1_addr, ex_rs2_addr, ex_reg_wr_addr,
             ex_RegWrite, ex_MemRead, ex_MemWrite, ex_mem_mask,
             ex_reg_wr_data, ex_mem_wr_data, ex_pc, ex_inst,
             mem_ready, wb_RegWrite, wb_reg_wr_addr, wb_reg_wr_data,
      input  ex_ready, mem_valid, mem_reg_wr_addr, mem_RegWrite, mem_MemRead,
             mem_MemWrite, mem_mem_mask, mem_reg_wr_data, mem_mem_wr_data,
             mem_pc, mem_inst, fw_src1fw, fw_src2fw, fw_ex_mem_data,
             fw_mem_wb_data, load_use_stall
   );

   // The EX/MEM register itself
   modport slave (
      input  flush, ex_valid, ex_rs1_addr, ex_rs2_addr, ex_reg_wr_addr,
             ex_RegWrite, ex_MemRead, ex_MemWrite, ex_mem_mask,
             ex_reg_wr_data, ex_mem_wr_data, ex_pc, ex_inst,
             mem_ready, wb_RegWrite, wb_reg_wr_addr, wb_reg_wr_data,
      output ex_ready, mem_valid, mem_reg_wr_addr, mem_RegWrite, mem_MemRead,
             mem_MemWrite, mem_mem_mask, mem_reg_wr_data, mem_mem_wr_data,
             mem_pc, mem_inst, fw_src1fw, fw_src2fw, fw_ex_mem_data,
             fw_mem_wb_data, load_use_stall
   );
endinterface

// File: rtl/ex_mem_pipe_fwd.sv
// EX->MEM pipeline register with forwarding selects and load-use stall generation.
// EX_MEM_FWD_EN defined: EX/MEM and MEM/WB forwarding; undefined: full interlock, selects tied to 00.
module ex_mem_pipe_fwd #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned RADDR_W = 5
) (
   input logic              clk,
   input logic              rst_n,
   ex_mem_pipe_fwd_if.slave bus
);
   localparam int unsigned MASK_W = 3;
   localparam int unsigned INST_W = 32;

   typedef struct packed {
      logic [RADDR_W-1:0] rd;
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic [MASK_W-1:0]  mask;
      logic [XLEN-1:0]    wr_data;
      logic [XLEN-1:0]    st_data;
      logic [XLEN-1:0]    pc;
      logic [INST_W-1:0]  inst;
   } payload_t;

   payload_t pay_q, pay_d, ex_pay;
   logic     valid_q, valid_d;
   logic     hit_m1, hit_m2, hit_w1, hit_w2;
   logic     stall;
   logic     ready;

   always_comb begin
      ex_pay           = '0;
      ex_pay.rd        = bus.ex_reg_wr_addr;
      ex_pay.reg_write = bus.ex_RegWrite;
      ex_pay.mem_read  = bus.ex_MemRead;
      ex_pay.mem_write = bus.ex_MemWrite;
      ex_pay.mask      = bus.ex_mem_mask;
      ex_pay.wr_data   = bus.ex_reg_wr_data;
      ex_pay.st_data   = bus.ex_mem_wr_data;
      ex_pay.pc        = bus.ex_pc;
      ex_pay.inst      = bus.ex_inst;
   end

   // x0 never matches, so it is neither forwarded nor interlocked on
   assign hit_m1 = valid_q & pay_q.reg_write & (pay_q.rd == bus.ex_rs1_addr) &
                   (bus.ex_rs1_addr != '0);
   assign hit_m2 = valid_q & pay_q.reg_write & (pay_q.rd == bus.ex_rs2_addr) &
                   (bus.ex_rs2_addr != '0);
   assign hit_w1 = bus.wb_RegWrite & (bus.wb_reg_wr_addr == bus.ex_rs1_addr) &
                   (bus.ex_rs1_addr != '0);
   assign hit_w2 = bus.wb_RegWrite & (bus.wb_reg_wr_addr == bus.ex_rs2_addr) &
                   (bus.ex_rs2_addr != '0);

`ifdef EX_MEM_FWD_EN
   // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet and stalls instead
   always_comb begin
      bus.fw_src1fw = 2'b00;
      bus.fw_src2fw = 2'b00;
      if (hit_m1 && !pay_q.mem_read) bus.fw_src1fw = 2'b10;
      else if (hit_w1)               bus.fw_src1fw = 2'b01;
      if (hit_m2 && !pay_q.mem_read) bus.fw_src2fw = 2'b10;
      else if (hit_w2)               bus.fw_src2fw = 2'b01;
   end
   assign stall = bus.ex_valid & (hit_m1 | hit_m2) & pay_q.mem_read;
`else
   assign bus.fw_src1fw = 2'b00;
   assign bus.fw_src2fw = 2'b00;
   assign stall = bus.ex_valid & (hit_m1 | hit_m2 | hit_w1 | hit_w2);
`endif

   assign ready              = (!valid_q | bus.mem_ready) & !stall;
   assign bus.ex_ready       = ready;
   assign bus.load_use_stall = stall;

   // Next entry: flush, then accept, then drain to a bubble, else hold
   always_comb begin
      valid_d = valid_q;
      pay_d   = pay_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (ready) begin
         valid_d = bus.ex_valid;
         if (bus.ex_valid) pay_d = ex_pay;
      end else if (valid_q && bus.mem_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pay_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pay_q   <= pay_d;
      end
   end

   assign bus.mem_valid       = valid_q;
   assign bus.mem_reg_wr_addr = pay_q.rd;
   assign bus.mem_RegWrite    = pay_q.reg_write;
   assign bus.mem_MemRead     = pay_q.mem_read;
   assign bus.mem_MemWrite    = pay_q.mem_write;
   assign bus.mem_mem_mask    = pay_q.mask;
   assign bus.mem_reg_wr_data = pay_q.wr_data;
   assign bus.mem_mem_wr_data = pay_q.st_data;
   assign bus.mem_pc          = pay_q.pc;
   assign bus.mem_inst        = pay_q.inst;
   assign bus.fw_ex_mem_data  = pay_q.wr_data;
   assign bus.fw_mem_wb_data  = bus.wb_reg_wr_data;
endmodule

// File: doc/ex_mem_pipe_fwd.md
Name: ex_mem_pipe_fwd

Overview:
- EX→MEM pipeline register with valid/ready handshake. It captures the EX stage's result bundle and presents it to the MEM stage.
- It is also the producing end of the EX forwarding interface. It generates the 2-bit src1/src2 forward selects and the EX/MEM and MEM/WB forward data that the EX stage muxes.
- It detects load-use hazards and stalls EX by inserting a bubble.

Parameters:
- XLEN, 64, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the EX/MEM entry (branch/jump redirect)
- ex_valid  in  1  EX bundle valid
- ex_ready  out  1  EX bundle accepted this cycle when ex_valid&ex_ready
- ex_rs1_addr  in  RADDR_W  rs1 of the instruction currently in EX
- ex_rs2_addr  in  RADDR_W  rs2 of the instruction currently in EX
- ex_reg_wr_addr  in  RADDR_W  rd
- ex_RegWrite, ex_MemRead, ex_MemWrite  in  1 each  control bits
- ex_mem_mask  in  3  load/store size mask
- ex_reg_wr_data  in  XLEN  ALU/link/LUI/AUIPC result
- ex_mem_wr_data  in  XLEN  store data
- ex_pc  in  XLEN  PC
- ex_inst  in  32  instruction word
- mem_valid  out  1  EX/MEM entry valid
- mem_ready  in  1  MEM stage accepts the entry
- mem_reg_wr_addr, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_mem_mask, mem_reg_wr_data, mem_mem_wr_data, mem_pc, mem_inst  out  same widths as the ex_* inputs  registered copies
- wb_RegWrite  in  1  MEM/WB entry writes rd (qualified by the WB valid)
- wb_reg_wr_addr  in  RADDR_W  MEM/WB rd
- wb_reg_wr_data  in  XLEN  MEM/WB final write data
- fw_src1fw, fw_src2fw  out  2  00 regfile, 01 MEM/WB, 10 EX/MEM
- fw_ex_mem_data  out  XLEN  equals mem_reg_wr_data
- fw_mem_wb_data  out  XLEN  equals wb_reg_wr_data
- load_use_stall  out  1  EX must hold

Behaviour:
- Reset (async, rst_n=0):
  - mem_valid=0; all mem_* payload registers=0.
  - Combinational outputs follow from those values: fw_*fw=00, load_use_stall=0, ex_ready=1.
- Hit definitions:
  - hitM(rs) = mem_valid & mem_RegWrite & mem_reg_wr_addr==rs & rs!=0.
  - hitW(rs) = wb_RegWrite & wb_reg_wr_addr==rs & rs!=0.
- Forward select (combinational):
  - 10 if hitM & !mem_MemRead.
  - else 01 if hitW.
  - else 00.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
- load_use_stall = (hitM(rs1)|hitM(rs2)) & mem_MemRead, evaluated only when ex_valid=1.
- ex_ready = (!mem_valid | mem_ready) & !load_use_stall.
- Register update on posedge clk, first matching rule wins:
  1. flush → mem_valid<=0, payload held.
  2. ex_ready → mem_valid<=ex_valid; payload<=ex_* when ex_valid.
  3. mem_valid & mem_ready → mem_valid<=0 (bubble inserted behind the load).
  4. Otherwise hold.
- Latency: one cycle EX→MEM. Back-to-back throughput of 1/cycle when mem_ready=1 and there is no hazard.
- Load-use costs exactly one bubble cycle. On the next cycle the load is in MEM/WB and the select becomes 01.
- mem_ready=0 with mem_valid=1: entry and payload are stable; ex_ready=0.
- Payload is frozen while invalid, so there is no toggling on bubbles.
- flush together with ex_valid: the EX bundle is dropped and mem_valid=0 next cycle.
- Reset deasserted mid-stall: resumes from the empty state.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - fw_src1fw and fw_src2fw are tied to 00.
  - load_use_stall = ex_valid & (hitM(rs1)|hitM(rs2)|hitW(rs1)|hitW(rs2)), regardless of MemRead.
  - Full interlock: EX waits until the producer has written the regfile.
  - fw_*_data outputs remain driven.

Test Plan:
1. Reset then release; check mem_valid=0, fw=00, ex_ready=1. Then issue addi x5 (rd=5, data=0x10), then add rs1=5 → second cycle fw_src1fw=10, fw_ex_mem_data=0x10, no stall.
2. ld x6 in EX/MEM (MemRead=1, rd=6) while EX holds rs2=6 → load_use_stall=1 and ex_ready=0 for 1 cycle, mem_valid=0 on the next edge. With wb_RegWrite=1, wb_addr=6, wb_data=0xDEAD the following cycle: fw_src2fw=01, stall=0.
3. Both EX/MEM and MEM/WB write rd=7 with data 0x1 and 0x2 respectively; EX rs1=7 → fw_src1fw=10, value 0x1. Separately, rs=0 with rd=0 on both → fw=00.
4. mem_ready=0 for 3 cycles with mem_valid=1 → ex_ready=0 and mem_* stable across all 3 cycles. mem_ready=1 → the next EX bundle is captured on the following edge.
5. flush=1 and ex_valid=1 on the same cycle, with mem_pc=0x80000000 valid → mem_valid=0 next cycle and the bundle is dropped. Assert rst_n=0 mid-operation → mem_valid clears immediately, asynchronously.
6. Compile without EX_MEM_FWD_EN; repeat scenario 1 → fw_src1fw=00 and stall=1 until wb_RegWrite is seen with addr 5 and cleared, then ex_ready=1.
